mc_control: RTL
===============

# mc_control

Multicycle control unit for the 16-bit accumulator-free datapath. It decodes the 4-bit opcode and sequences fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, and handshakes with a single-ported memory that can stall. It sits beside the datapath in the CPU top level, with its outputs wired one-to-one to the datapath control inputs.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; state forced to FETCH while low
- op  input  4  instr[15:12] from datapath
- zero  input  1  ALU zero flag (live, combinational)
- memready  input  1  memory completes current read/write this cycle
- pcen, irwrite, regwrite, memwrite  output  1  datapath/memory enables
- alusrca, iord, memtoreg, regdst  output  1  mux selects
- alusrcb  output  2  00 B, 01 const 2, 10 signimm, 11 signimm<<1
- pcsrc  output  2  00 aluresult, 01 aluout, 10 jump target
- alucontrol  output  3  000 add, 001 sub, 010 nand
- illegal  output  1  one-cycle pulse on undefined opcode
- halted  output  1  core stopped (only with CTRL_HALT_EN)

## Operation
- Opcodes:
  - 0000 ADD
  - 0010 NAND
  - 0001 ADDI
  - 0100 LW
  - 0101 SW
  - 1100 BEQ
  - 1000 JMP
  - 1101 CALL
  - 1111 HALT (config)
  - Others illegal.
- FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=000, pcsrc=00.
  - irwrite = pcen = memready.
  - Stay while memready=0; on memready go to DECODE.
- DECODE: alusrca=0, alusrcb=11, add. Aluout captures the branch target. Dispatch on op:
  - ADD/NAND to EXEC
  - ADDI to ADDIEX
  - LW/SW to MEMADR
  - BEQ to BRANCH
  - JMP to JUMP
  - CALL to CALL
  - HALT to HALT
  - Illegal: pulse illegal, go to FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol = 000 (ADD) or 010 (NAND). Next state ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
  - The datapath applies the carry/zero condition bits itself; the controller asserts regwrite unconditionally.
- ADDIEX: alusrca=1, alusrcb=10, add. Next state ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. Go to MEMRD (LW) or MEMWR (SW).
- MEMRD: iord=1. Wait for memready, then go to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
- MEMWR: iord=1, memwrite=1 held until memready. Go to FETCH in the memready cycle.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Go to FETCH.
- JUMP: pcsrc=10, pcen=1. Go to FETCH.
- CALL: pcsrc=10, pcen=1, regwrite=1, regdst=0. Go to FETCH.
  - The datapath substitutes pc+2 as write data.
- Any output not listed for a state is 0.

## Timing
- State register updates on posedge clk.
- Outputs are combinational from state, plus the memready/zero qualification noted above.
- Reset behaviour:
  - Asynchronous reset to FETCH.
  - pcen, irwrite, regwrite and memwrite are forced 0 while reset=0.
  - illegal=0 and halted=0 during reset.
- Cycles per instruction with zero wait states:
  - BEQ, JMP, CALL: 3
  - ADD, NAND, ADDI, SW: 4
  - LW: 5
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Memory requests (FETCH, MEMRD, MEMWR) hold iord and memwrite stable until memready; no abort.
- memready asserted outside those states is ignored.
- Reset mid-instruction abandons the instruction; no enable is asserted after reset falls.
- zero is sampled only in BRANCH; a glitch in any other state has no effect.

## Configuration
- CTRL_HALT_EN defined:
  - Opcode 1111 goes DECODE to HALT.
  - HALT asserts halted=1 and all enables 0, and remains there until reset.
- CTRL_HALT_EN undefined:
  - 1111 is illegal (illegal pulse, return to FETCH).
  - No HALT state; halted tied 0.

## Test plan
- Reset low mid-MEMWR with memready=0: state returns to FETCH immediately, memwrite=0 while reset=0; after release, first fetch completes on memready.
- ADD with memready=1 always: exactly 4 cycles FETCH->DECODE->EXEC->ALUWB; regwrite=1, regdst=1 in cycle 4; pcen=1 only in cycle 1.
- LW with memready low 2 cycles in MEMRD: iord=1 for 3 cycles, MEMWB one cycle later with memtoreg=1; total 7 cycles.
- BEQ with zero=1 and then with zero=0: pcen=1 with pcsrc=01 in cycle 3 only when zero=1; 3 cycles both cases.
- Opcode 0111: illegal pulses exactly one cycle in DECODE, no regwrite, memwrite or pcen beyond fetch; next state FETCH.
- Opcode 1111: with CTRL_HALT_EN, halted=1 indefinitely and memready toggling causes no enable; without it, behaves as the 0111 case.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back and drives datapath enables.
// Optional HALT opcode support is enabled by defining CTRL_HALT_EN.
module mc_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic       halted
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_CALL = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP,
`ifdef CTRL_HALT_EN
        S_HALT,
`endif
        S_CALL
    } state_t;

    state_t state_q, state_d;
    logic   pcen_c, irwrite_c, regwrite_c, memwrite_c, illegal_c, halted_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pcen_c     = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        illegal_c  = 1'b0;
        halted_c   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        unique case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_c = memready;
                pcen_c    = memready;
                if (memready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU computes the branch target here so aluout holds it for BRANCH
                alusrcb = 2'b11;
                unique case (op)
                    OP_ADD, OP_NAND: state_d = S_EXEC;
                    OP_ADDI:         state_d = S_ADDIEX;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_JMP:          state_d = S_JUMP;
                    OP_CALL:         state_d = S_CALL;
`ifdef CTRL_HALT_EN
                    OP_HALT:         state_d = S_HALT;
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alusrca    = 1'b1;
                alucontrol = (op == OP_NAND) ? 3'b010 : 3'b000;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                regdst     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (memready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (memready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b001;
                pcsrc      = 2'b01;
                pcen_c     = zero;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcen_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_CALL: begin
                // datapath supplies pc+2 as the link write data
                pcsrc      = 2'b10;
                pcen_c     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef CTRL_HALT_EN
            S_HALT: halted_c = 1'b1;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are gated so nothing fires while reset is held, even in FETCH
    assign pcen     = pcen_c     & reset;
    assign irwrite  = irwrite_c  & reset;
    assign regwrite = regwrite_c & reset;
    assign memwrite = memwrite_c & reset;
    assign illegal  = illegal_c  & reset;
`ifdef CTRL_HALT_EN
    assign halted   = halted_c   & reset;
`else
    assign halted   = 1'b0;
`endif
endmodule
